// File: rtl/trace_accumulator_pkg.sv
// Shared state encoding and width helpers for the trace accumulator.
// Widths are derived here so the top and the RMW pipe always agree.
package trace_accumulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } acq_state_t;

  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Accumulator must hold AVG_N full-scale samples without wrapping.
  function automatic int acc_w_f(input int data_w, input int avg_n);
    return data_w + clog2_f(avg_n);
  endfunction

  function automatic int addr_w_f(input int rec_len);
    return clog2_f(rec_len);
  endfunction

endpackage

// File: rtl/trace_accumulator_rmw_pipe.sv
// Three-cycle read-add-write path into the external trace RAM, plus the
// sticky overrun flag for strobes that arrive while a pass is in flight.
module rmw_pipe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              flush,
  input  logic              clr_err,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [ADDR_W-1:0] sample_addr,
  input  logic [ACC_W-1:0]  ram_rd_data,
  output logic              accept,
  output logic              inflight,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ACC_W-1:0]  wr_data,
  output logic              err_overrun
);

  logic              s1_valid;
  logic              s2_valid;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] s2_data;
  logic [ADDR_W-1:0] s1_addr;
  logic [ADDR_W-1:0] s2_addr;
  logic [ACC_W-1:0]  s2_rd;

  assign inflight = s1_valid | s2_valid;
  assign accept   = sample_valid & ~inflight;

  // Stage 1 waits on the RAM read; stage 2 holds the read word for the write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s2_data  <= '0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      s2_rd    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        s1_data <= sample_data;
        s1_addr <= sample_addr;
      end
      if (s1_valid) begin
        s2_data <= s1_data;
        s2_addr <= s1_addr;
        s2_rd   <= ram_rd_data;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_overrun <= 1'b0;
    end else if (clr_err) begin
      err_overrun <= 1'b0;
    end else if (sample_valid && inflight) begin
      err_overrun <= 1'b1;
    end
  end

  assign wr_en   = s2_valid & ~flush;
  assign wr_addr = s2_addr;
  assign wr_data = s2_rd + ACC_W'(s2_data);

endmodule

// File: rtl/trace_accumulator.sv
// Averaging trace accumulator: sums AVG_N records of REC_LEN samples in an
// external RAM, then streams the per-index sums (or means) out.
module trace_accumulator
  import trace_accumulator_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REC_LEN = 10,
  parameter  int AVG_N   = 4,
  localparam int ACC_W   = acc_w_f(DATA_W, AVG_N),
  localparam int ADDR_W  = addr_w_f(REC_LEN)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mean_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [ACC_W-1:0]  ram_wr_data,
  input  logic [ACC_W-1:0]  ram_rd_data,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  localparam int SHIFT = clog2_f(AVG_N);
  localparam int CNT_W = clog2_f(AVG_N);

  acq_state_t        state;
  acq_state_t        next_state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  rec_cnt;
  logic              mean_r;
  logic              rd_pend;
  logic              out_valid_r;
  logic [ACC_W-1:0]  out_data_r;

  logic              idx_last;
  logic              rec_last;
  logic              first_wr;
  logic              rmw_valid;
  logic              rmw_accept;
  logic              rmw_inflight;
  logic              rmw_wr_en;
  logic [ADDR_W-1:0] rmw_wr_addr;
  logic [ACC_W-1:0]  rmw_wr_data;
  logic              start_go;
  logic              drain_issue;
  logic              handshake;

  assign idx_last    = (idx == ADDR_W'(REC_LEN - 1));
  assign rec_last    = (rec_cnt == CNT_W'(AVG_N - 1));
  assign first_wr    = (state == ST_FIRST) && in_valid && !abort;
  assign rmw_valid   = (state == ST_ACCUM) && in_valid && !abort;
  assign start_go    = (state == ST_IDLE) && start && !abort;
  assign handshake   = out_valid_r && out_ready;
  assign drain_issue = (state == ST_DRAIN) && !rmw_inflight && !rd_pend && !out_valid_r;

  rmw_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) u_rmw (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .flush        (abort),
    .clr_err      (start_go),
    .sample_valid (rmw_valid),
    .sample_data  (in_data),
    .sample_addr  (idx),
    .ram_rd_data  (ram_rd_data),
    .accept       (rmw_accept),
    .inflight     (rmw_inflight),
    .wr_en        (rmw_wr_en),
    .wr_addr      (rmw_wr_addr),
    .wr_data      (rmw_wr_data),
    .err_overrun  (err_overrun)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) next_state = ST_FIRST;
        ST_FIRST: if (in_valid && idx_last) next_state = ST_ACCUM;
        ST_ACCUM: if (rmw_accept && idx_last && rec_last) next_state = ST_DRAIN;
        ST_DRAIN: if (handshake && idx_last) next_state = ST_DONE;
        ST_DONE:  next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Drain reads wait for the last RMW write to retire, since the RAM has one port.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx         <= '0;
      rec_cnt     <= '0;
      mean_r      <= 1'b0;
      rd_pend     <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (abort) begin
      idx         <= '0;
      rec_cnt     <= '0;
      rd_pend     <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx     <= '0;
            rec_cnt <= '0;
            mean_r  <= mean_mode;
          end
        end
        ST_FIRST, ST_ACCUM: begin
          if ((state == ST_FIRST) ? in_valid : rmw_accept) begin
            idx <= idx_last ? '0 : idx + ADDR_W'(1);
            if (idx_last) rec_cnt <= rec_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          rd_pend <= drain_issue;
          if (rd_pend) begin
            out_data_r  <= mean_r ? (ram_rd_data >> SHIFT) : ram_rd_data;
            out_valid_r <= 1'b1;
          end else if (handshake) begin
            out_valid_r <= 1'b0;
            idx         <= idx_last ? '0 : idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_wr_en   = first_wr | rmw_wr_en;
  assign ram_addr    = rmw_wr_en ? rmw_wr_addr : idx;
  assign ram_wr_data = rmw_wr_en ? rmw_wr_data : (first_wr ? ACC_W'(in_data) : '0);
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_trace_accumulator.sv
// Randomized self-checking bench for trace_accumulator with an external RAM
// model and a record-sum reference computed from the accepted sample stream.
module tb_trace_accumulator;

  localparam int DATA_W  = 8;
  localparam int REC_LEN = 4;
  localparam int AVG_N   = 4;
  localparam int ACC_W   = 10;
  localparam int ADDR_W  = 2;

  logic              sys_clk;
  logic              sys_rst_n;
  logic              start;
  logic              abort;
  logic              mean_mode;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr_en;
  logic [ACC_W-1:0]  ram_wr_data;
  logic [ACC_W-1:0]  ram_rd_data;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err_overrun;

  logic [ACC_W-1:0] mem [REC_LEN];

  int  total_checks = 0;
  int  bad_checks   = 0;
  int  exp_sum [REC_LEN];
  bit  exp_mean;
  bit  exp_over;

  trace_accumulator #(
    .DATA_W  (DATA_W),
    .REC_LEN (REC_LEN),
    .AVG_N   (AVG_N)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .abort       (abort),
    .mean_mode   (mean_mode),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .ram_addr    (ram_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .err_overrun (err_overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Single-port synchronous RAM, one-cycle read latency.
  always @(posedge sys_clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    total_checks++;
    if (observed != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int expWord(input int i);
    return exp_mean ? (exp_sum[i] >> 2) : exp_sum[i];
  endfunction

  // Drives one acquisition; a strobe within two cycles of the previous
  // accumulated one is expected to be dropped once the first record is in.
  task automatic applyStimulus(input bit mean, input int data_mode, input int min_gap,
                               input int max_gap, input bit extra, input bit poke_start,
                               input int abort_after);
    int accepted;
    int last_acc;
    int now;
    int gap;
    int v;
    accepted = 0;
    last_acc = -100;
    now      = 0;
    for (int i = 0; i < REC_LEN; i++) exp_sum[i] = 0;
    exp_over  = 1'b0;
    exp_mean  = mean;
    mean_mode = mean;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    mean_mode = 1'($urandom_range(0, 1));
    while (accepted < REC_LEN * AVG_N) begin
      gap = $urandom_range(min_gap, max_gap);
      repeat (gap - 1) begin
        tick();
        now++;
      end
      if (abort_after >= 0 && accepted == abort_after) begin
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        return;
      end
      case (data_mode)
        0:       v = (accepted % REC_LEN) + 1;
        1:       v = 255;
        default: v = $urandom_range(0, 255);
      endcase
      in_data  = DATA_W'(v);
      in_valid = 1'b1;
      if (poke_start && accepted == REC_LEN + 1) start = 1'b1;
      if (accepted < REC_LEN || now - last_acc >= 3) begin
        exp_sum[accepted % REC_LEN] += v;
        if (accepted >= REC_LEN) last_acc = now;
        accepted++;
      end else begin
        exp_over = 1'b1;
      end
      tick();
      now++;
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = DATA_W'($urandom_range(0, 255));
    end
    if (extra) begin
      in_valid = 1'b1;
      in_data  = 8'd200;
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic drainAndCheck(input int stall_word, input bit rand_ready);
    int got;
    int budget;
    int stall_left;
    bit seen_done;
    bit stalled;
    bit holding;
    bit prev_hs;
    logic [ACC_W-1:0] held;
    got = 0; budget = 0; stall_left = 0;
    seen_done = 0; stalled = 0; holding = 0; prev_hs = 0; held = '0;
    while (!seen_done && budget < 600) begin
      tick();
      out_ready = (stall_left > 0) ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (stall_left > 0) stall_left--;
      @(negedge sys_clk);
      budget++;
      if (prev_hs) checkOutput("gap_valid_low", out_valid, 0);
      prev_hs = 0;
      if (done) begin
        seen_done = 1;
        checkOutput("words_before_done", got, REC_LEN);
        checkOutput("overrun_flag", err_overrun, exp_over);
      end else begin
        if (out_valid && got == stall_word && !stalled) begin
          stalled    = 1;
          stall_left = 20;
          out_ready  = 1'b0;
        end
        if (holding) begin
          checkOutput("hold_valid", out_valid, 1);
          checkOutput("hold_data", out_data, held);
        end
        if (out_valid && out_ready) begin
          if (got < REC_LEN) checkOutput($sformatf("word%0d", got), out_data, expWord(got));
          else               checkOutput("extra_word", out_valid, 0);
          got++;
          prev_hs = 1;
          holding = 0;
        end else if (out_valid) begin
          holding = 1;
          held    = out_data;
        end else begin
          holding = 0;
        end
      end
    end
    checkOutput("drain_finished", seen_done, 1);
    out_ready = 1'b0;
    @(negedge sys_clk);
    checkOutput("idle_after_done", busy, 0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    mean_mode = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_wr_en", ram_wr_en, 0);
    checkOutput("rst_addr", ram_addr, 0);
    checkOutput("rst_overrun", err_overrun, 0);
    sys_rst_n = 1'b1;
    tick();

    $display("[TB] ramp records, sum");
    applyStimulus(1'b0, 0, 3, 3, 1'b1, 1'b0, -1);
    drainAndCheck(-1, 1'b0);

    $display("[TB] ramp records, mean");
    applyStimulus(1'b1, 0, 3, 3, 1'b0, 1'b0, -1);
    drainAndCheck(-1, 1'b0);

    $display("[TB] full-scale samples with mid-drain stall");
    applyStimulus(1'b0, 1, 3, 4, 1'b0, 1'b0, -1);
    drainAndCheck(1, 1'b0);

    $display("[TB] back-to-back strobes during accumulation");
    applyStimulus(1'b0, 2, 1, 1, 1'b0, 1'b0, -1);
    drainAndCheck(-1, 1'b1);

    $display("[TB] abort during accumulation, then fresh run");
    applyStimulus(1'b0, 2, 1, 3, 1'b0, 1'b0, REC_LEN + 2);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_wr_en", ram_wr_en, 0);
    checkOutput("abort_out_valid", out_valid, 0);
    tick();
    checkOutput("abort_beats_start", busy, 0);
    applyStimulus(1'b1, 2, 3, 5, 1'b0, 1'b0, -1);
    drainAndCheck(-1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      $display("[TB] random run %0d", r);
      applyStimulus(1'($urandom_range(0, 1)), 2, 1, 5, 1'($urandom_range(0, 1)), 1'b1, -1);
      drainAndCheck($urandom_range(0, REC_LEN - 1), 1'b1);
    end

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 2, 2, 3, 1'b0, 1'b0, 3);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    tick();
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkOutput("midrst_still_idle", busy, 0);
    checkOutput("midrst_no_done", done, 0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
